// File: rtl/chacha_qr_serdes.sv
// rtl/chacha_qr_serdes.sv - byte-serial load/unload front end around the ChaCha quarter-round core
module chacha_qr_serdes #(
  parameter int ROUNDS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  input  logic         go,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  output logic         busy,
  output logic [127:0] qr_in,
  output logic         qr_start,
  input  logic         qr_done,
  input  logic [127:0] qr_out
);

  localparam logic [7:0] ROUNDS_L = ROUNDS[7:0];

  typedef enum logic [2:0] {
    S_LOAD,
    S_FULL,
    S_RUN,
    S_WAIT,
    S_UNLOAD
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [127:0] data_q;
  logic [3:0]   byte_cnt;
  logic [7:0]   round_cnt;

  logic load_en;
  logic go_en;
  logic done_en;
  logic pop_en;

  // Next-state decode; each strobe is only honoured in the one state that uses it.
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    go_en   = 1'b0;
    done_en = 1'b0;
    pop_en  = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          load_en = 1'b1;
          if (byte_cnt == 4'd15) state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (go) begin
          go_en   = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (qr_done) begin
          done_en = 1'b1;
          state_d = (round_cnt == 8'd1) ? S_UNLOAD : S_RUN;
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          pop_en = 1'b1;
          if (byte_cnt == 4'd15) state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // State register; ena low freezes the whole block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Buffer and counters: byte writes in LOAD, whole-block overwrite on each core result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      byte_cnt  <= 4'd0;
      round_cnt <= 8'd0;
    end else if (ena) begin
      if (load_en) begin
        data_q[{byte_cnt, 3'b000} +: 8] <= in_byte;
      end
      if (load_en || pop_en) begin
        byte_cnt <= byte_cnt + 4'd1;
      end
      if (go_en) begin
        round_cnt <= ROUNDS_L;
      end
      if (done_en) begin
        data_q    <= qr_out;
        round_cnt <= round_cnt - 8'd1;
        byte_cnt  <= 4'd0;
      end
    end
  end

  // Outputs decode registered state only, so out_ready never reaches out_byte/out_valid.
  always_comb begin
    out_valid = (state_q == S_UNLOAD);
    busy      = (state_q == S_RUN) || (state_q == S_WAIT);
    qr_start  = (state_q == S_RUN) && ena;
    qr_in     = data_q;
    out_byte  = out_valid ? data_q[{byte_cnt, 3'b000} +: 8] : 8'h00;
  end

endmodule

// File: tb/tb_chacha_qr_serdes.sv
// tb/tb_chacha_qr_serdes.sv - scoreboard bench for chacha_qr_serdes with ROUNDS=1 and ROUNDS=3 instances
module tb_chacha_qr_serdes;

  logic         clk;
  logic         rst_n;
  logic         ena;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         go;
  logic         out_ready1;
  logic         out_ready3;
  logic         spur;

  logic [7:0]   out_byte1, out_byte3;
  logic         out_valid1, out_valid3;
  logic         busy1, busy3;
  logic [127:0] qr_in1, qr_in3;
  logic         qr_start1, qr_start3;
  logic         qr_done1, qr_done3;
  logic [127:0] qr_out1, qr_out3;

  logic         pend1, pend3, done1_m, done3_m;
  logic [127:0] cap1, cap3;

  int errors;
  int checks;
  int pops1, pops3;
  int starts1, starts3;
  logic prev_done1, prev_done3;
  logic [7:0] sb1[$];
  logic [7:0] sb3[$];

  logic [7:0] rfc_out [16] = '{8'hf4, 8'h92, 8'h2a, 8'hea, 8'hce, 8'hf8, 8'h1c, 8'hcb,
                               8'h2e, 8'h47, 8'h81, 8'h45, 8'hbb, 8'hc4, 8'h81, 8'h58};

  chacha_qr_serdes #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_byte(in_byte), .in_valid(in_valid), .go(go),
    .out_ready(out_ready1), .out_byte(out_byte1), .out_valid(out_valid1), .busy(busy1),
    .qr_in(qr_in1), .qr_start(qr_start1), .qr_done(qr_done1), .qr_out(qr_out1)
  );

  chacha_qr_serdes #(.ROUNDS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_byte(in_byte), .in_valid(in_valid), .go(go),
    .out_ready(out_ready3), .out_byte(out_byte3), .out_valid(out_valid3), .busy(busy3),
    .qr_in(qr_in3), .qr_start(qr_start3), .qr_done(qr_done3), .qr_out(qr_out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] qr_fn(input logic [127:0] x);
    logic [31:0] a, b, c, d;
    a = x[31:0]; b = x[63:32]; c = x[95:64]; d = x[127:96];
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {d, c, b, a};
  endfunction

  // Core models with latency 2: qr_done two cycles after the qr_start cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend1 <= 1'b0; done1_m <= 1'b0; cap1 <= '0; qr_out1 <= '0;
    end else begin
      pend1   <= qr_start1;
      done1_m <= pend1;
      if (qr_start1) cap1 <= qr_in1;
      if (pend1) qr_out1 <= qr_fn(cap1);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend3 <= 1'b0; done3_m <= 1'b0; cap3 <= '0; qr_out3 <= '0;
    end else begin
      pend3   <= qr_start3;
      done3_m <= pend3;
      if (qr_start3) cap3 <= qr_in3;
      if (pend3) qr_out3 <= qr_fn(cap3);
    end
  end

  assign qr_done1 = done1_m | spur;
  assign qr_done3 = done3_m | spur;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample on the falling edge (pops, start pulses), return 1 unit after the rising edge.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    if (out_valid1 && out_ready1) begin
      pops1++;
      if (sb1.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb1_underflow observed=%0h expected=none", out_byte1);
      end else begin
        e = sb1.pop_front();
        chk8("out_byte1", out_byte1, e);
      end
    end
    if (out_valid3 && out_ready3) begin
      pops3++;
      if (sb3.size() == 0) begin
        checks++; errors++;
        $error("FAIL sb3_underflow observed=%0h expected=none", out_byte3);
      end else begin
        e = sb3.pop_front();
        chk8("out_byte3", out_byte3, e);
      end
    end
    if (qr_start1) begin
      if (starts1 > 0) begin
        chk128("qr_in_chain1", qr_in1, qr_out1);
        chk1("start_after_done1", prev_done1, 1'b1);
      end
      starts1++;
    end
    if (qr_start3) begin
      if (starts3 > 0) begin
        chk128("qr_in_chain3", qr_in3, qr_out3);
        chk1("start_after_done3", prev_done3, 1'b1);
      end
      starts3++;
    end
    prev_done1 = qr_done1;
    prev_done3 = qr_done3;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] v, input bit abuse);
    for (int i = 0; i < 16; i++) begin
      if (abuse && i == 8) begin
        in_valid = 1'b0; go = 1'b1;
        step();
        go = 1'b0;
        chk1("go_in_load_busy", busy1, 1'b0);
      end
      in_byte  = v[8*i +: 8];
      in_valid = 1'b1;
      go       = abuse && (i == 15);
      step();
    end
    in_valid = 1'b0;
    go       = 1'b0;
    chk128("loaded_qr_in1", qr_in1, v);
    chk128("loaded_qr_in3", qr_in3, v);
    chk1("full_busy1", busy1, 1'b0);
    chk1("full_busy3", busy3, 1'b0);
  endtask

  task automatic start_job(input logic [127:0] e1, input logic [127:0] e3);
    for (int i = 0; i < 16; i++) begin
      sb1.push_back(e1[8*i +: 8]);
      sb3.push_back(e3[8*i +: 8]);
    end
    starts1 = 0; starts3 = 0; pops1 = 0; pops3 = 0;
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic wait_both();
    for (int k = 0; k < 60; k++) begin
      if (out_valid1 && out_valid3) break;
      step();
    end
    chk1("wait_valid1", out_valid1, 1'b1);
    chk1("wait_valid3", out_valid3, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_out_valid1"}, out_valid1, 1'b0);
    chk1({tag, "_out_valid3"}, out_valid3, 1'b0);
    chk1({tag, "_busy1"}, busy1, 1'b0);
    chk1({tag, "_busy3"}, busy3, 1'b0);
    chk1({tag, "_qr_start3"}, qr_start3, 1'b0);
    chk8({tag, "_out_byte3"}, out_byte3, 8'h00);
    chk128({tag, "_qr_in1"}, qr_in1, 128'h0);
    chk128({tag, "_qr_in3"}, qr_in3, 128'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    sb1.delete();
    sb3.delete();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [127:0] vec, rfc_exp, v;
    int lat1, lat3, n;

    errors = 0; checks = 0; pops1 = 0; pops3 = 0; starts1 = 0; starts3 = 0;
    prev_done1 = 1'b0; prev_done3 = 1'b0;
    rst_n = 1'b0; ena = 1'b1; in_byte = 8'h00; in_valid = 1'b0; go = 1'b0;
    out_ready1 = 1'b0; out_ready3 = 1'b0; spur = 1'b0;
    vec = 128'h01234567_9b8d6f43_01020304_11111111;
    for (int i = 0; i < 16; i++) rfc_exp[8*i +: 8] = rfc_out[i];

    // Reset, then idle for ten cycles with no strobes.
    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk1("idle_out_valid1", out_valid1, 1'b0);
      chk1("idle_qr_start1", qr_start1, 1'b0);
      chk8("idle_out_byte1", out_byte1, 8'h00);
      chk1("idle_busy3", busy3, 1'b0);
    end

    // ena low: strobes are ignored.
    ena = 1'b0; in_byte = 8'hAA; in_valid = 1'b1;
    repeat (2) step();
    ena = 1'b1; in_valid = 1'b0;
    chk128("ena_low_qr_in1", qr_in1, 128'h0);

    // RFC vector load with a stray go mid-load and a go coinciding with the last byte.
    load(vec, 1'b1);

    // FULL abuse: in_valid and spurious qr_done are ignored.
    in_byte = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0; spur = 1'b1;
    step();
    spur = 1'b0;
    chk128("full_abuse_qr_in1", qr_in1, vec);
    chk128("full_abuse_qr_in3", qr_in3, vec);
    chk1("full_abuse_busy3", busy3, 1'b0);

    // Job 1: latency measurement, in_valid held high throughout.
    in_byte = 8'h5A; in_valid = 1'b1;
    lat1 = 0; lat3 = 0;
    start_job(rfc_exp, qr_fn(qr_fn(qr_fn(vec))));
    chk1("run_qr_start1", qr_start1, 1'b1);
    for (int k = 2; k <= 40; k++) begin
      step();
      if (out_valid1 && lat1 == 0) lat1 = k;
      if (out_valid3 && lat3 == 0) lat3 = k;
      if (lat3 != 0) break;
    end
    in_valid = 1'b0;
    chki("latency1", lat1, 4);
    chki("latency3", lat3, 10);
    chki("starts1", starts1, 1);
    chki("starts3", starts3, 3);

    // Drain ROUNDS=1 back to back.
    out_ready1 = 1'b1; n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      n++;
      if (!out_valid1) break;
    end
    out_ready1 = 1'b0;
    chki("drain1_cycles", n, 16);
    chki("drain1_pops", pops1, 16);
    chki("drain1_sb_left", sb1.size(), 0);
    chk1("drain1_back_to_load", busy1, 1'b0);

    // Drain ROUNDS=3 with out_ready gaps.
    for (int k = 0; k < 100; k++) begin
      out_ready3 = ((k % 3) != 2);
      step();
      if (!out_valid3) break;
    end
    out_ready3 = 1'b0;
    chki("drain3_pops", pops3, 16);
    chki("drain3_sb_left", sb3.size(), 0);
    chk1("drain3_out_valid", out_valid3, 1'b0);

    // Reset mid-UNLOAD after seven pops.
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    load(v, 1'b0);
    start_job(qr_fn(v), qr_fn(qr_fn(qr_fn(v))));
    wait_both();
    out_ready3 = 1'b1;
    repeat (7) step();
    out_ready3 = 1'b0;
    chki("mid_unload_pops", pops3, 7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_unload");
    do_reset();

    // Reset mid-WAIT.
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    load(v, 1'b0);
    start_job(qr_fn(v), qr_fn(qr_fn(qr_fn(v))));
    for (int k = 0; k < 20; k++) begin
      if (busy3 && !qr_start3) break;
      step();
    end
    chk1("wait_state_busy3", busy3, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    do_reset();

    // Fresh load after reset works normally.
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    load(v, 1'b0);
    start_job(qr_fn(v), qr_fn(qr_fn(qr_fn(v))));
    wait_both();
    out_ready1 = 1'b1; out_ready3 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!out_valid1 && !out_valid3) break;
    end
    out_ready1 = 1'b0; out_ready3 = 1'b0;
    chki("fresh_pops1", pops1, 16);
    chki("fresh_pops3", pops3, 16);
    chki("fresh_sb1_left", sb1.size(), 0);
    chki("fresh_sb3_left", sb3.size(), 0);
    chki("fresh_starts3", starts3, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
